// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types, constants and helpers for the truth-table sweeper
//
// Purpose: FSM state encoding, derived-size functions (samples per word,
// word count, counter widths) and a popcount helper used by the sweeper.
// Ports: none (package).
package tt_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SWEEP = 2'd1;
  localparam state_t EMIT  = 2'd2;

  // Number of vector samples packed into one truth-table word.
  function automatic int samples_per_word(input int word_w, input int n_out);
    return word_w / n_out;
  endfunction

  // Number of words needed to cover all 2^n_in vectors (last may be partial).
  function automatic int num_words(input int n_in, input int s);
    return ((1 << n_in) + s - 1) / s;
  endfunction

  // err_vec can reach 2^n_in, so it needs one bit more than the vector.
  function automatic int err_vec_width(input int n_in);
    return n_in + 1;
  endfunction

  // err_bit can reach 2^n_in * n_out.
  function automatic int err_bit_width(input int n_in, input int n_out);
    return n_in + 1 + $clog2(n_out + 1);
  endfunction

  // Partition output widths are at most 32 bits.
  function automatic int popcount(input logic [31:0] x);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(x[i]);
    return c;
  endfunction

endpackage

// File: rtl/tt_packer.sv
// rtl/tt_packer.sv - insert register that packs per-vector samples into a word
//
// Purpose: holds the partially built truth-table word and the slot index of
// the next sample. word_next is the pack register with the current sample
// already inserted, so the owner can capture a completed word on the same
// edge that writes its final sample.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr         clear pack register and slot index (takes priority over wr_en)
//   wr_en       insert din at the current slot and advance the slot
//   din         N_OUT-bit sample for the current vector
//   word_next   pack register with din inserted at the current slot
//   full        current slot is the last slot in the word
import tt_sweep_pkg::*;

module tt_packer #(
  parameter int N_OUT  = 1,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [N_OUT-1:0]  din,
  output logic [WORD_W-1:0] word_next,
  output logic              full
);

  localparam int S      = samples_per_word(WORD_W, N_OUT);
  localparam int SLOT_W = (S > 1) ? $clog2(S) : 1;

  logic [WORD_W-1:0] pack;
  logic [SLOT_W-1:0] slot;

  always_comb begin
    word_next = pack;
    word_next[slot*N_OUT +: N_OUT] = din;
  end

  assign full = (slot == SLOT_W'(S - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pack <= '0;
      slot <= '0;
    end else if (wr_en) begin
      pack <= word_next;
      slot <= full ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/partition_tt_sweeper.sv
// rtl/partition_tt_sweeper.sv - sweeps all partition input vectors, packs and scores outputs
//
// Purpose: drives every input vector into an approximate and an exact
// partition, packs the approximate outputs into WORD_W-bit words streamed
// out with a valid/ready handshake, and counts vector and bit mismatches.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, abort        begin sweep (IDLE only) / abandon sweep
//   vec_o               registered input vector to both partitions
//   approx_i, exact_i   partition outputs for vec_o
//   tt_data, tt_valid   packed approximate truth-table word and its valid
//   tt_ready            downstream accepts tt_data
//   busy, done          sweep in progress / sweep completed (level)
//   err_vec, err_bit    mismatching vectors / mismatching output bits
import tt_sweep_pkg::*;

module partition_tt_sweeper #(
  parameter int N_IN   = 11,
  parameter int N_OUT  = 1,
  parameter int WORD_W = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  output logic [N_IN-1:0]                        vec_o,
  input  logic [N_OUT-1:0]                       approx_i,
  input  logic [N_OUT-1:0]                       exact_i,
  output logic [WORD_W-1:0]                      tt_data,
  output logic                                   tt_valid,
  input  logic                                   tt_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic [N_IN:0]                          err_vec,
  output logic [N_IN+1+$clog2(N_OUT+1)-1:0]      err_bit
);

  localparam int ERR_VEC_W = err_vec_width(N_IN);
  localparam int ERR_BIT_W = err_bit_width(N_IN, N_OUT);

  state_t              state;
  logic [N_OUT-1:0]    diff;
  logic                mism;
  logic                last;
  logic                full;
  logic [WORD_W-1:0]   word_next;
  logic [ERR_BIT_W-1:0] bit_inc;
  logic                pack_clr;
  logic                pack_wr;

  assign diff    = approx_i ^ exact_i;
  assign mism    = |diff;
  assign last    = &vec_o;
  assign bit_inc = ERR_BIT_W'(popcount(32'(diff)));
  assign busy    = (state != IDLE);

  // The pack register is emptied when a sweep begins and after every
  // accepted word; it is only written while sampling in SWEEP.
  assign pack_clr = ((state == IDLE) && start && !abort) ||
                    ((state == EMIT) && tt_ready && !abort);
  assign pack_wr  = (state == SWEEP) && !abort;

  tt_packer #(
    .N_OUT  (N_OUT),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .wr_en     (pack_wr),
    .din       (approx_i),
    .word_next (word_next),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec_o    <= '0;
      tt_data  <= '0;
      tt_valid <= 1'b0;
      done     <= 1'b0;
      err_vec  <= '0;
      err_bit  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort in IDLE masks a simultaneous start
          if (start && !abort) begin
            state   <= SWEEP;
            vec_o   <= '0;
            err_vec <= '0;
            err_bit <= '0;
            done    <= 1'b0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            done     <= 1'b0;
          end else begin
            err_vec <= err_vec + ERR_VEC_W'(mism);
            err_bit <= err_bit + bit_inc;
            if (full || last) begin
              tt_data  <= word_next;
              tt_valid <= 1'b1;
              state    <= EMIT;
            end else begin
              vec_o <= vec_o + N_IN'(1);
            end
          end
        end
        EMIT: begin
          if (abort) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            done     <= 1'b0;
          end else if (tt_ready) begin
            tt_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              vec_o <= vec_o + N_IN'(1);
              state <= SWEEP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_partition_tt_sweeper.sv
// tb/tb_partition_tt_sweeper.sv - self-checking bench for partition_tt_sweeper
module tb_partition_tt_sweeper;

  localparam int N_IN   = 11;
  localparam int N_OUT  = 1;
  localparam int WORD_W = 32;
  localparam int NV     = 1 << N_IN;
  localparam int S      = WORD_W / N_OUT;
  localparam int NW     = (NV + S - 1) / S;
  localparam int LAT    = NV + NW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                tt_ready = 1'b0;
  logic [N_IN-1:0]     vec_o;
  logic [N_OUT-1:0]    approx_i;
  logic [N_OUT-1:0]    exact_i;
  logic [WORD_W-1:0]   tt_data;
  logic                tt_valid;
  logic                busy;
  logic                done;
  logic [N_IN:0]       err_vec;
  logic [N_IN+1:0]     err_bit;

  bit                  a_tab [NV];
  bit                  e_tab [NV];
  logic [WORD_W-1:0]   exp_words [NW];
  int                  exp_ev;
  int                  exp_eb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // The partitions under test are modelled as lookup tables of vec_o.
  always_comb begin
    approx_i = a_tab[vec_o];
    exact_i  = e_tab[vec_o];
  end

  partition_tt_sweeper #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .WORD_W (WORD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .vec_o    (vec_o),
    .approx_i (approx_i),
    .exact_i  (exact_i),
    .tt_data  (tt_data),
    .tt_valid (tt_valid),
    .tt_ready (tt_ready),
    .busy     (busy),
    .done     (done),
    .err_vec  (err_vec),
    .err_bit  (err_bit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word w bit i is the approximate output of vector w*S+i.
  task automatic set_mode(input int m);
    for (int v = 0; v < NV; v++) begin
      case (m)
        0: begin a_tab[v] = v[0];          e_tab[v] = v[0];     end
        1: begin a_tab[v] = !v[0];         e_tab[v] = 1'b0;     end
        2: begin a_tab[v] = ^v[10:0];      e_tab[v] = ^v[10:1]; end
        default: begin
          a_tab[v] = 1'($urandom_range(0, 1));
          e_tab[v] = 1'($urandom_range(0, 1));
        end
      endcase
    end
    exp_ev = 0;
    for (int w = 0; w < NW; w++) exp_words[w] = '0;
    for (int v = 0; v < NV; v++) begin
      exp_words[v / S][v % S] = a_tab[v];
      if (a_tab[v] != e_tab[v]) exp_ev++;
    end
    exp_eb = exp_ev;
  endtask

  function automatic int mism_below(input int n);
    int c;
    c = 0;
    for (int v = 0; v < n; v++) if (a_tab[v] != e_tab[v]) c++;
    return c;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vec"},   vec_o,    0);
    chk({tag, "_data"},  tt_data,  0);
    chk({tag, "_valid"}, tt_valid, 0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_ev"},    err_vec,  0);
    chk({tag, "_eb"},    err_bit,  0);
  endtask

  // Full sweep from IDLE; optional stall of stall_n cycles on word stall_word
  // and an optional start pulse while busy.
  task automatic run_sweep(input string tag, input int stall_word, input int stall_n,
                           input bit spurious);
    int cyc, words, stalled;
    logic [WORD_W-1:0] held_d;
    logic [N_IN-1:0]   held_v;
    held_d = '0;
    held_v = '0;
    tt_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_acc_busy"}, busy, 1);
    chk({tag, "_acc_done"}, done, 0);
    chk({tag, "_acc_vec"},  vec_o, 0);
    cyc = 0;
    words = 0;
    stalled = 0;
    while (!done && cyc < LAT + stall_n + 200) begin
      start = (spurious && cyc == 100);
      if (tt_valid && words == stall_word && stalled < stall_n) begin
        if (stalled == 0) begin
          held_d = tt_data;
          held_v = vec_o;
        end else begin
          chk($sformatf("%s_stall_data%0d", tag, stalled), tt_data, held_d);
          chk($sformatf("%s_stall_vec%0d", tag, stalled), vec_o, held_v);
        end
        tt_ready = 1'b0;
        stalled++;
      end else begin
        tt_ready = 1'b1;
      end
      if (tt_valid && tt_ready) begin
        if (words < NW) chk($sformatf("%s_word%0d", tag, words), tt_data, exp_words[words]);
        words++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, LAT + stall_n);
    chk({tag, "_nwords"},  words, NW);
    chk({tag, "_done"},    done, 1);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_err_vec"}, err_vec, exp_ev);
    chk({tag, "_err_bit"}, err_bit, exp_eb);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    set_mode(0);
    run_sweep("ident", -1, 0, 1'b0);
    set_mode(1);
    run_sweep("inv", -1, 0, 1'b0);
    set_mode(2);
    run_sweep("parity", -1, 0, 1'b0);
    set_mode(3);
    run_sweep("stall", 5, 10, 1'b1);

    // abort mid-sweep, counters keep partial values
    tt_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_o != 300 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach300", vec_o, 300);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_valid", tt_valid, 0);
    chk("abort_vec",   vec_o, 300);
    chk("abort_ev",    err_vec, mism_below(300));
    chk("abort_eb",    err_bit, mism_below(300));
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_masks_start", busy, 0);
    run_sweep("post_abort", -1, 0, 1'b0);

    // reset while holding a word in EMIT
    set_mode(2);
    tt_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!tt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("emit_reached", tt_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("emit_reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep("post_reset", -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
